// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: level/almost-full/sticky overflow.
// Optional idle-line timeout is compiled in with `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 4,
    parameter int AFULL_LVL     = 12,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clken_16bps,
    input  logic [DATA_W-1:0] rxd_data,
    input  logic              rxd_flag,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              timeout
);

    localparam int              DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_AFULL = (ADDR_W+1)'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_nxt;
    logic              rd_acc;
    logic              wr_acc;
    logic              drop;

    // A read frees the slot a same-cycle write needs, so a full FIFO still accepts.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = rxd_flag && (!full || rd_acc);
    assign drop   = rxd_flag && full && !rd_acc;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc)
            level_nxt = level + 1'b1;
        else if (rd_acc && !wr_acc)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= rxd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            rd_valid    <= rd_acc;
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            full        <= (level_nxt == LVL_FULL);
            almost_full <= (level_nxt >= LVL_AFULL);
            // A drop in the same cycle as the clear wins, so no loss goes unreported.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CHARS * 160);

    logic [15:0] idle_cnt;
    logic [15:0] idle_cnt_nxt;
    logic        idle_clr;

    assign idle_clr = wr_acc || rd_acc || empty;

    always_comb begin
        idle_cnt_nxt = idle_cnt;
        if (idle_clr)
            idle_cnt_nxt = '0;
        else if (clken_16bps && idle_cnt != '1)
            idle_cnt_nxt = idle_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt_nxt;
            timeout  <= !idle_clr && (idle_cnt_nxt >= TO_LIMIT);
        end
    end
`else
    localparam int unused_timeout_chars = TIMEOUT_CHARS;
    logic unused_clken;

    assign unused_clken = clken_16bps;
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed table-driven bench for uart_rx_fifo plus hand sequences for reset and timeout.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clken_16bps = 1'b0;
    logic [7:0] rxd_data = '0;
    logic       rxd_flag = 1'b0;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;
    logic       timeout;

    uart_rx_fifo #(
        .DATA_W        (8),
        .ADDR_W        (4),
        .AFULL_LVL     (12),
        .TIMEOUT_CHARS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clken_16bps (clken_16bps),
        .rxd_data    (rxd_data),
        .rxd_flag    (rxd_flag),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Observed bundle: {level, rd_valid, rd_data, empty, full, almost_full, overflow}
    logic [17:0] obs;
    assign obs = {level, rd_valid, rd_data, empty, full, almost_full, overflow};

    typedef struct {
        logic        flag;
        logic [7:0]  din;
        logic        rd;
        logic        clr;
        logic [17:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic logic [17:0] e(input int lvl, input logic vld, input logic [7:0] dout,
                                      input logic emp, input logic ful, input logic af,
                                      input logic ovf);
        return {5'(lvl), vld, dout, emp, ful, af, ovf};
    endfunction

    function automatic vec_t v(input logic flag, input logic [7:0] din, input logic rd,
                               input logic clr, input logic [17:0] exp, input string name);
        vec_t t;
        t.flag = flag; t.din = din; t.rd = rd; t.clr = clr; t.exp = exp; t.name = name;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic flag, input logic [7:0] din, input logic rd, input logic clr);
        rxd_flag = flag;
        rxd_data = din;
        rd_en    = rd;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
        rxd_flag = 1'b0;
        rd_en    = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    initial begin
        // Table: starts from empty FIFO with rd_data=0x33 after the reset sequence.
        vecs.push_back(v(0, 8'h00, 0, 0, e(0, 0, 8'h33, 1, 0, 0, 0), "idle"));
        for (int k = 1; k <= 16; k++)
            vecs.push_back(v(1, 8'(k-1), 0, 0,
                             e(k, 0, 8'h33, 0, k == 16, k >= 12, 0), "push"));
        vecs.push_back(v(1, 8'hAA, 0, 0, e(16, 0, 8'h33, 0, 1, 1, 1), "drop_aa"));
        vecs.push_back(v(1, 8'h12, 0, 1, e(16, 0, 8'h33, 0, 1, 1, 1), "clr_with_drop"));
        vecs.push_back(v(0, 8'h00, 0, 1, e(16, 0, 8'h33, 0, 1, 1, 0), "clr_alone"));
        vecs.push_back(v(1, 8'h55, 1, 0, e(16, 1, 8'h00, 0, 1, 1, 0), "rw_at_full"));
        for (int j = 1; j <= 15; j++)
            vecs.push_back(v(0, 8'h00, 1, 0,
                             e(16-j, 1, 8'(j), 0, 0, (16-j) >= 12, 0), "pop"));
        vecs.push_back(v(0, 8'h00, 1, 0, e(0, 1, 8'h55, 1, 0, 0, 0), "pop_last_55"));
        vecs.push_back(v(0, 8'h00, 1, 0, e(0, 0, 8'h55, 1, 0, 0, 0), "rd_on_empty"));
        vecs.push_back(v(1, 8'h77, 1, 0, e(1, 0, 8'h55, 0, 0, 0, 0), "rw_on_empty"));
        vecs.push_back(v(0, 8'h00, 1, 0, e(0, 1, 8'h77, 1, 0, 0, 0), "pop_77"));
        vecs.push_back(v(0, 8'h00, 0, 0, e(0, 0, 8'h77, 1, 0, 0, 0), "idle_after"));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(obs), 32'(e(0, 0, 8'h00, 1, 0, 0, 0)));
        check("reset_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of operation
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        check("pre_reset_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset", 32'(obs), 32'(e(0, 0, 8'h00, 1, 0, 0, 0)));
        rst_n = 1'b1;
        cycle(1, 8'h33, 0, 0);
        check("post_reset_push", 32'(obs), 32'(e(1, 0, 8'h00, 0, 0, 0, 0)));
        cycle(0, 8'h00, 1, 0);
        check("post_reset_pop", 32'(obs), 32'(e(0, 1, 8'h33, 1, 0, 0, 0)));

        foreach (vecs[i]) begin
            cycle(vecs[i].flag, vecs[i].din, vecs[i].rd, vecs[i].clr);
            check($sformatf("%s[%0d]", vecs[i].name, i), 32'(obs), 32'(vecs[i].exp));
        end

        // Idle-line timeout
        cycle(1, 8'h99, 0, 0);
        check("to_push", 32'(obs), 32'(e(1, 0, 8'h77, 0, 0, 0, 0)));
        clken_16bps = 1'b1;
        repeat (639) @(posedge clk);
        #1;
        check("to_639", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        clken_16bps = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        check("to_640", 32'(timeout), 32'd1);
        @(posedge clk);
        #1;
        check("to_held", 32'(timeout), 32'd1);
`else
        check("to_640_off", 32'(timeout), 32'd0);
`endif
        cycle(0, 8'h00, 1, 0);
        check("to_pop_data", 32'(obs), 32'(e(0, 1, 8'h99, 1, 0, 0, 0)));
        check("to_clear", 32'(timeout), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. Each single-cycle rxd_flag strobe from the receiver pushes the accompanying rxd_data byte into a circular FIFO. The FIFO decouples the receiver from the slower host/bus logic that drains it. Provides level, almost-full, sticky overflow and an optional idle-line timeout indication.

Parameters:
DATA_W, 8, byte width; matches receiver rxd_data.
ADDR_W, 4, pointer width; depth = 2**ADDR_W = 16 entries.
AFULL_LVL, 12, level at or above which almost_full asserts.
TIMEOUT_CHARS, 4, idle character times before timeout asserts (optional feature only).

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
clken_16bps  input  1  16x baud clock enable, same strobe the receiver uses.
rxd_data  input  DATA_W  received byte; valid only while rxd_flag=1.
rxd_flag  input  1  one-cycle write strobe from receiver.
rd_en  input  1  pop request from consumer.
rd_data  output  DATA_W  popped byte, registered.
rd_valid  output  1  one-cycle pulse: rd_data updated this cycle.
empty  output  1  level==0.
full  output  1  level==2**ADDR_W.
almost_full  output  1  level>=AFULL_LVL.
level  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
overflow  output  1  sticky; byte dropped because FIFO was full.
ovf_clr  input  1  clears overflow.
timeout  output  1  idle-line timeout with data pending (0 if feature compiled out).

Behaviour:
- Reset (async): wr_ptr=rd_ptr=0, level=0, rd_data=0, rd_valid=0, empty=1, full=0, almost_full=0, overflow=0, timeout=0. Storage contents not reset.
- Pointers ADDR_W bits, wrap 2**ADDR_W-1 -> 0. Separate level counter of ADDR_W+1 bits; full/empty derived from level, registered alongside it.
- Write accepted: rxd_flag=1 and (!full or read accepted same cycle). mem[wr_ptr]<=rxd_data, wr_ptr+1.
- Read accepted: rd_en=1 and !empty. rd_data<=mem[rd_ptr], rd_ptr+1, rd_valid=1 next cycle (latency 1). rd_en on empty: ignored, rd_valid=0, rd_data holds.
- Simultaneous accepted read+write: level unchanged. When full, both proceed; no overflow. When empty, only the write proceeds.
- Level: +1 on write only, -1 on read only, unchanged otherwise. Never exceeds 2**ADDR_W and never underflows.
- Overflow: rxd_flag=1, full=1, no read accepted -> byte discarded, pointers unchanged, overflow<=1. Stays set until ovf_clr=1. Set condition and ovf_clr in the same cycle -> overflow stays 1.
- rd_data holds last popped value between reads.
- No other state machine: the FIFO is pointer/counter controlled. The timeout counter below is the only other sequential element.
- rxd_flag assumed ≤1 per 160 clken_16bps ticks. The FIFO does not rely on this for correctness.

Optional Feature:
Macro UART_RX_FIFO_TIMEOUT_EN.
- Defined: 16-bit saturating idle counter increments on each clken_16bps while !empty.
- Counter clears to 0 on accepted write, accepted read, or empty=1.
- timeout<=1 when counter reaches TIMEOUT_CHARS*160 (16 ticks × 10 bits per char). Held until the next counter clear; deasserts the cycle after the clearing event.
- Not defined: no counter logic; timeout tied to 0.

Test Plan:
- Reset mid-operation: push 0x11,0x22, assert rst_n=0 one cycle -> level=0, empty=1, overflow=0, rd_data=0; subsequent pop of 0x33 returns 0x33.
- Ordering: push 0x00..0x0F (16 strobes) -> full=1, almost_full asserted at level 12. Pop 16 -> rd_data sequence 0x00..0x0F, each with rd_valid one cycle after rd_en, then empty=1.
- Overflow: fill 16, push 0xAA -> overflow=1, level=16; pop first = 0x00, 0xAA never appears. ovf_clr together with another dropped write -> overflow stays 1. ovf_clr alone -> 0.
- Simultaneous at full: level=16, rxd_flag with 0x55 and rd_en same cycle -> level stays 16, overflow=0, 0x55 read out last.
- Empty read / empty+write: rd_en on empty -> rd_valid=0, pointers fixed. rd_en+rxd_flag(0x77) when empty -> level=1, rd_valid=0, next pop returns 0x77.
- Timeout (macro defined, TIMEOUT_CHARS=4): push one byte, apply 639 clken_16bps ticks -> timeout=0; 640th tick -> timeout=1; pop -> timeout=0 next cycle. Macro undefined -> timeout=0 throughout.
